keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner with column synchronisation, press/release debounce and optional auto-repeat. It drives one row low at a time and samples the active-low columns through a two-flop synchroniser. On a debounced press it emits a one-cycle `key_valid` strobe with an encoded `key_code`. It sits between the keypad pins and the key-decode / display logic, and supersedes the fixed 4x4 scanner.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 178 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding and width helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } statetype;

  // Largest of four timing parameters; sizes the single shared counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to hold the values 0..v, never less than one.
  function automatic int width_for(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

  // Bits needed to index n items, never less than one.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - two-flop synchroniser for the raw active-low column inputs
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two flop stages; reset loads ones so an idle (pulled-up) keypad is seen.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad scanner with debounce and optional auto-repeat
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NROWS         = 4,
  parameter int NCOLS         = 4,
  parameter int SETTLE        = 3,
  parameter int DEBOUNCE      = 8,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NCOLS-1:0]                cols,
  output logic [NROWS-1:0]                rows,
  output logic                            key_valid,
  output logic [$clog2(NROWS*NCOLS)-1:0]  key_code,
  output logic                            key_held
);

  localparam int ROW_W  = idx_width(NROWS);
  localparam int COL_W  = idx_width(NCOLS);
  localparam int CODE_W = $clog2(NROWS * NCOLS);
  localparam int CNT_W  = width_for(max4(SETTLE, DEBOUNCE, REPEAT_DELAY, REPEAT_PERIOD));

  localparam bit               REPEAT_ON   = (REPEAT_DELAY > 0);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(NROWS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] RD_LAST     = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST     = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  statetype         r_state;
  statetype         w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] w_row_next;
  logic [ROW_W-1:0] w_row_inc;
  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] w_col_next;
  logic             r_rep_started;
  logic             w_rep_started_next;
  logic             w_strobe;

  logic [NCOLS-1:0]  w_scol;
  logic              w_any_low;
  logic [COL_W-1:0]  w_low_col;
  logic              w_key_low;
  logic [CODE_W-1:0] w_code;

  logic [NROWS-1:0]  r_rows;
  logic              r_key_valid;
  logic [CODE_W-1:0] r_key_code;
  logic              r_key_held;

  keypad_sync #(.W(NCOLS)) u_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (cols),
    .o_q     (w_scol)
  );

  // Lowest-indexed low column in the active row wins among simultaneous presses.
  always_comb begin
    w_any_low = 1'b0;
    w_low_col = '0;
    for (int i = NCOLS - 1; i >= 0; i--) begin
      if (!w_scol[i]) begin
        w_any_low = 1'b1;
        w_low_col = COL_W'(i);
      end
    end
  end

  assign w_key_low = ~w_scol[r_col];
  assign w_row_inc = (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_code    = CODE_W'(int'(r_row) * NCOLS + int'(r_col));

  // Next-state logic; the counter is cleared on every transition and every repeat strobe.
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = w_cnt_inc;
    w_row_next         = r_row;
    w_col_next         = r_col;
    w_rep_started_next = r_rep_started;
    w_strobe           = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt_next = '0;
          if (w_any_low) begin
            w_col_next   = w_low_col;
            w_state_next = ST_DEBOUNCE;
          end else begin
            w_row_next = w_row_inc;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (!w_key_low) begin
          w_state_next = ST_SCAN;
          w_row_next   = w_row_inc;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next       = ST_HELD;
          w_cnt_next         = '0;
          w_strobe           = 1'b1;
          w_rep_started_next = 1'b0;
        end
      end
      ST_HELD: begin
        if (!w_key_low) begin
          w_state_next = ST_RELEASE;
          w_cnt_next   = '0;
        end else if (REPEAT_ON) begin
          // First repeat waits the full delay, later ones the shorter period.
          if (r_cnt == (r_rep_started ? RP_LAST : RD_LAST)) begin
            w_strobe           = 1'b1;
            w_cnt_next         = '0;
            w_rep_started_next = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (w_key_low) begin
          w_state_next       = ST_HELD;
          w_cnt_next         = '0;
          w_rep_started_next = 1'b0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = ST_SCAN;
          w_row_next   = w_row_inc;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = ST_SCAN;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, counter, latched key and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_SCAN;
      r_cnt         <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_rep_started <= 1'b0;
      r_rows        <= ~NROWS'(1);
      r_key_valid   <= 1'b0;
      r_key_code    <= '0;
      r_key_held    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_row         <= w_row_next;
      r_col         <= w_col_next;
      r_rep_started <= w_rep_started_next;
      r_rows        <= ~(NROWS'(1) << w_row_next);
      r_key_valid   <= w_strobe;
      if (w_strobe) begin
        r_key_code <= w_code;
      end
      r_key_held    <= (w_state_next == ST_HELD) || (w_state_next == ST_RELEASE);
    end
  end

  assign rows      = r_rows;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } press_vec_t;

  logic            clk;
  logic            reset;
  logic [3:0]      cols;
  logic [3:0]      rows;
  logic            key_valid;
  logic [3:0]      key_code;
  logic            key_held;
  logic [3:0]      rep_cols;
  logic [3:0]      rep_rows;
  logic            rep_key_valid;
  logic [3:0]      rep_key_code;
  logic            rep_key_held;
  logic [3:0][3:0] mat;
  logic [3:0][3:0] mat_rep;

  int n_pass;
  int n_total;
  int n_strobes;
  int n_consec;
  int cyc;
  logic prev_valid;

  keypad_scanner dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  keypad_scanner #(
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (10)
  ) dut_rep (
    .clk       (clk),
    .reset     (reset),
    .cols      (rep_cols),
    .rows      (rep_rows),
    .key_valid (rep_key_valid),
    .key_code  (rep_key_code),
    .key_held  (rep_key_held)
  );

  function automatic logic [3:0] keypad(input logic [3:0] rw, input logic [3:0][3:0] m);
    logic [3:0] cv;
    cv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m[r][c] && !rw[r]) cv[c] = 1'b0;
    return cv;
  endfunction

  assign cols     = keypad(rows, mat);
  assign rep_cols = keypad(rep_rows, mat_rep);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) n_strobes++;
    if (key_valid && prev_valid) n_consec++;
    prev_valid = key_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_strobe(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_and_check(input int r, input logic [3:0] code);
    int n;
    logic [3:0] exp_rows;
    mat = '0;
    n = 0;
    while (key_held && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("release_cycles", n, 11);
    exp_rows = ~(4'b0001 << ((r + 1) % 4));
    chk("resume_row", rows, exp_rows);
    chk("code_holds", key_code, code);
  endtask

  initial begin
    press_vec_t tbl[5];
    logic [3:0] exp_rows;
    bit ok;
    int base;
    int t0;
    int offs[$];
    int exp_offs[4];

    tbl[0] = '{r: 2, c: 1, code: 4'd9};
    tbl[1] = '{r: 0, c: 0, code: 4'd0};
    tbl[2] = '{r: 3, c: 3, code: 4'd15};
    tbl[3] = '{r: 1, c: 2, code: 4'd6};
    tbl[4] = '{r: 3, c: 0, code: 4'd12};
    exp_offs = '{20, 30, 40, 50};

    n_pass = 0; n_total = 0; n_strobes = 0; n_consec = 0; cyc = 0;
    prev_valid = 1'b0;
    mat = '0;
    mat_rep = '0;
    reset = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_rows", rows, 4'b1110);
    chk("reset_valid", key_valid, 0);
    chk("reset_code", key_code, 0);
    chk("reset_held", key_held, 0);
    reset = 1'b0;

    // Idle scan: each row low for three cycles in turn.
    for (int k = 0; k < 48; k++) begin
      exp_rows = ~(4'b0001 << ((k / 3) % 4));
      chk("idle_rows", rows, exp_rows);
      @(negedge clk);
    end
    chk("idle_no_strobe", n_strobes, 0);

    // Clean presses from the vector table.
    for (int i = 0; i < 5; i++) begin
      base = n_strobes;
      mat[tbl[i].r][tbl[i].c] = 1'b1;
      wait_strobe(100, ok);
      chk("press_seen", ok, 1);
      chk("press_code", key_code, tbl[i].code);
      chk("press_held", key_held, 1);
      @(negedge clk);
      chk("strobe_one_cycle", key_valid, 0);
      repeat (20) @(negedge clk);
      chk("held_while_down", key_held, 1);
      release_and_check(tbl[i].r, tbl[i].code);
      chk("press_strobe_count", n_strobes - base, 1);
    end

    // Press bounce, then a stable press, then a short release bounce.
    base = n_strobes;
    for (int k = 0; k < 30; k++) begin
      mat[0][3] = ((k / 3) % 2 == 0);
      @(negedge clk);
    end
    chk("bounce_no_strobe", n_strobes - base, 0);
    mat[0][3] = 1'b1;
    wait_strobe(100, ok);
    chk("bounce_seen", ok, 1);
    chk("bounce_code", key_code, 3);
    repeat (15) @(negedge clk);
    mat[0][3] = 1'b0;
    repeat (5) @(negedge clk);
    mat[0][3] = 1'b1;
    repeat (20) @(negedge clk);
    chk("rel_bounce_held", key_held, 1);
    chk("rel_bounce_strobes", n_strobes - base, 1);
    release_and_check(0, 4'd3);

    // Two columns in one row, then a second key elsewhere while held.
    base = n_strobes;
    mat[1][0] = 1'b1;
    mat[1][2] = 1'b1;
    wait_strobe(100, ok);
    chk("multi_seen", ok, 1);
    chk("multi_code", key_code, 4);
    repeat (5) @(negedge clk);
    mat[3][3] = 1'b1;
    repeat (40) @(negedge clk);
    chk("multi_second_ignored", n_strobes - base, 1);
    chk("multi_code_kept", key_code, 4);
    release_and_check(1, 4'd4);

    // Auto-repeat on the second instance.
    mat_rep[1][1] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rep_key_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rep_first_seen", ok, 1);
    chk("rep_first_code", rep_key_code, 5);
    t0 = cyc;
    for (int i = 0; i < 55; i++) begin
      @(negedge clk);
      if (rep_key_valid) begin
        offs.push_back(cyc - t0);
        chk("rep_code", rep_key_code, 5);
      end
    end
    chk("rep_count", offs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rep_offset", (i < offs.size()) ? offs[i] : -1, exp_offs[i]);
    end
    mat_rep = '0;

    // Reset pulse while a key is held.
    mat[0][1] = 1'b1;
    wait_strobe(100, ok);
    chk("rst_press_seen", ok, 1);
    chk("rst_press_code", key_code, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mat = '0;
    chk("rst_rows", rows, 4'b1110);
    chk("rst_held", key_held, 0);
    chk("rst_code", key_code, 0);
    chk("rst_valid", key_valid, 0);
    base = n_strobes;
    repeat (20) @(negedge clk);
    chk("rst_no_strobe_after", n_strobes - base, 0);

    chk("no_consecutive_strobe", n_consec, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
